// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 800x600@72 timing defaults, RGB332 field positions and shared types
package vga_pkg;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 56;
    localparam int DEF_H_SYNC   = 120;
    localparam int DEF_H_BP     = 64;
    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FP     = 37;
    localparam int DEF_V_SYNC   = 6;
    localparam int DEF_V_BP     = 23;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int R_MSB = 7;
    localparam int R_LSB = 5;
    localparam int G_MSB = 4;
    localparam int G_LSB = 2;
    localparam int B_MSB = 1;
    localparam int B_LSB = 0;

    localparam logic [9:0] BLANK_COORD = 10'h3FF;

    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
        logic first;
    } vga_ctl_t;

    function automatic logic [7:0] bar_color(input logic [2:0] idx);
        return {{3{idx[2]}}, {3{idx[1]}}, {2{idx[0]}}};
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - reset-clearable shift register of parameterised depth (0 = wire)
module vga_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign o_q = i_d;
        end else begin : g_dly
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
                end else begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters, framebuffer-aligned RGB332 and sync output stage
// Optional colour-bar test pattern with TEST_MODE port: define VGA_TEST_PATTERN_EN.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int H_POL    = 1,
    parameter int V_POL    = 1,
    parameter int PIPE_DLY = 1
) (
    input  logic       PIXEL_CLK,
    input  logic       RST,
`ifdef VGA_TEST_PATTERN_EN
    input  logic       TEST_MODE,
`endif
    input  logic [7:0] PIXEL_DATA,
    output logic [9:0] HC_O,
    output logic [9:0] VC_O,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic [2:0] RED,
    output logic [2:0] GREEN,
    output logic [1:0] BLUE,
    output logic       FRAME_START
);

    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START  = H_ACTIVE + H_FP;
    localparam int HS_END    = HS_START + H_SYNC;
    localparam int VS_START  = V_ACTIVE + V_FP;
    localparam int VS_END    = VS_START + V_SYNC;
    localparam logic HS_ON   = H_POL[0];
    localparam logic VS_ON   = V_POL[0];
    localparam int CTL_W     = $bits(vga_ctl_t);

    logic [10:0] r_h_cnt;
    logic [10:0] r_v_cnt;
    logic        w_h_last;
    logic        w_v_last;
    vga_ctl_t    w_ctl;
    vga_ctl_t    w_ctl_d;
    logic [7:0]  w_pix;

    assign w_h_last = (r_h_cnt == 11'(H_TOTAL - 1));
    assign w_v_last = (r_v_cnt == 11'(V_TOTAL - 1));

    always_ff @(posedge PIXEL_CLK) begin
        if (RST) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? 11'd0 : r_v_cnt + 11'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 11'd1;
        end
    end

    assign w_ctl.active = (r_h_cnt < 11'(H_ACTIVE)) && (r_v_cnt < 11'(V_ACTIVE));
    assign w_ctl.hs     = (r_h_cnt >= 11'(HS_START)) && (r_h_cnt < 11'(HS_END));
    assign w_ctl.vs     = (r_v_cnt >= 11'(VS_START)) && (r_v_cnt < 11'(VS_END));
    assign w_ctl.first  = (r_h_cnt == 11'd0) && (r_v_cnt == 11'd0);

    assign HC_O = w_ctl.active ? r_h_cnt[9:0] : BLANK_COORD;
    assign VC_O = w_ctl.active ? r_v_cnt[9:0] : BLANK_COORD;

`ifdef VGA_TEST_PATTERN_EN
    // The column travels with the control bits so the bar edge lines up with the pixel data.
    localparam int BAR_W = H_ACTIVE / 8;
    logic [9:0]       w_h_d;
    logic [2:0]       w_bar_idx;
    logic [CTL_W+9:0] w_dly_q;

    vga_delay_line #(.DEPTH(PIPE_DLY), .WIDTH(CTL_W + 10)) u_dly (
        .i_clk (PIXEL_CLK),
        .i_rst (RST),
        .i_d   ({r_h_cnt[9:0], w_ctl}),
        .o_q   (w_dly_q)
    );

    assign w_h_d     = w_dly_q[CTL_W+9:CTL_W];
    assign w_ctl_d   = w_dly_q[CTL_W-1:0];
    assign w_bar_idx = 3'(w_h_d / 10'(BAR_W));
    assign w_pix     = TEST_MODE ? bar_color(w_bar_idx) : PIXEL_DATA;
`else
    vga_delay_line #(.DEPTH(PIPE_DLY), .WIDTH(CTL_W)) u_dly (
        .i_clk (PIXEL_CLK),
        .i_rst (RST),
        .i_d   (w_ctl),
        .o_q   (w_ctl_d)
    );

    assign w_pix = PIXEL_DATA;
`endif

    logic       r_hsync;
    logic       r_vsync;
    logic [2:0] r_red;
    logic [2:0] r_green;
    logic [1:0] r_blue;
    logic       r_frame_start;

    always_ff @(posedge PIXEL_CLK) begin
        if (RST) begin
            r_hsync       <= ~HS_ON;
            r_vsync       <= ~VS_ON;
            r_red         <= '0;
            r_green       <= '0;
            r_blue        <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= w_ctl_d.hs ? HS_ON : ~HS_ON;
            r_vsync       <= w_ctl_d.vs ? VS_ON : ~VS_ON;
            r_red         <= w_ctl_d.active ? w_pix[R_MSB:R_LSB] : 3'd0;
            r_green       <= w_ctl_d.active ? w_pix[G_MSB:G_LSB] : 3'd0;
            r_blue        <= w_ctl_d.active ? w_pix[B_MSB:B_LSB] : 2'd0;
            r_frame_start <= w_ctl_d.first;
        end
    end

    assign HSYNC       = r_hsync;
    assign VSYNC       = r_vsync;
    assign RED         = r_red;
    assign GREEN       = r_green;
    assign BLUE        = r_blue;
    assign FRAME_START = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - bench for vga_timing_gen: full horizontal timing, shortened vertical frame
module tb_vga_timing_gen;

    localparam int LAT   = 2;
    localparam int HT    = 1040;
    localparam int VT    = 12;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pix = 8'd0;
    logic [9:0] hc, vc;
    logic       hs, vs, fs;
    logic [2:0] r, g;
    logic [1:0] b;

    always #10 clk = ~clk;

    // Vertical timing shrunk (6 active, fp 2, sync 2, bp 2) so whole frames fit in a short run.
    vga_timing_gen #(
        .H_ACTIVE(800), .H_FP(56), .H_SYNC(120), .H_BP(64),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .H_POL(1), .V_POL(1), .PIPE_DLY(1)
    ) dut (
        .PIXEL_CLK   (clk),
        .RST         (rst),
`ifdef VGA_TEST_PATTERN_EN
        .TEST_MODE   (1'b0),
`endif
        .PIXEL_DATA  (pix),
        .HC_O        (hc),
        .VC_O        (vc),
        .HSYNC       (hs),
        .VSYNC       (vs),
        .RED         (r),
        .GREEN       (g),
        .BLUE        (b),
        .FRAME_START (fs)
    );

    int t = 0;
    always @(posedge clk) begin
        if (rst) t <= 0;
        else     t <= t + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            if (bad <= 30) $display("FAIL %s t=%0d actual=%h required=%h", nm, t, act, exp_v);
        end
    endtask

    function automatic logic [10:0] pk(input logic h_s, input logic v_s, input logic [2:0] rr,
                                       input logic [2:0] gg, input logic [1:0] bb, input logic f);
        return {h_s, v_s, rr, gg, bb, f};
    endfunction

    function automatic logic [9:0] exp_hc(input int tt);
        int h, v;
        h = tt % HT;
        v = (tt / HT) % VT;
        return (h < 800 && v < 6) ? 10'(h) : 10'h3FF;
    endfunction

    function automatic logic [9:0] exp_vc(input int tt);
        int h, v;
        h = tt % HT;
        v = (tt / HT) % VT;
        return (h < 800 && v < 6) ? 10'(v) : 10'h3FF;
    endfunction

    // Pin values produced by counter state tt, with the framebuffer returning HC_O[7:0].
    function automatic logic [10:0] exp_pins(input int tt);
        int h, v;
        logic act;
        logic [7:0] x;
        h   = tt % HT;
        v   = (tt / HT) % VT;
        act = (h < 800) && (v < 6);
        x   = 8'(h);
        return pk((h >= 856) && (h < 976), (v >= 8) && (v < 10),
                  act ? x[7:5] : 3'd0, act ? x[4:2] : 3'd0, act ? x[1:0] : 2'd0,
                  (h == 0) && (v == 0));
    endfunction

    // Framebuffer stand-in: one-cycle registered read of HC_O.
    initial begin
        logic [9:0] w;
        forever begin
            @(negedge clk);
            w = hc;
            @(posedge clk);
            #1 pix = w[7:0];
        end
    end

    logic [10:0] sb_q[$];
    int          fs_q[$];

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                sb_q.delete();
                for (int i = 0; i < LAT; i++) sb_q.push_back(11'd0);
            end else begin
                sb_q.push_back(exp_pins(t));
                if (sb_q.size() > LAT) chk("sb_pins", {21'd0, hs, vs, r, g, b, fs}, {21'd0, sb_q.pop_front()});
                chk("sb_hc", {22'd0, hc}, {22'd0, exp_hc(t)});
                chk("sb_vc", {22'd0, vc}, {22'd0, exp_vc(t)});
                if (fs) fs_q.push_back(t);
            end
        end
    end

    typedef struct {
        int          t;
        logic [9:0]  hc;
        logic [9:0]  vc;
        logic [10:0] pins;
    } vec_t;

    vec_t tbl[18];

    task automatic wait_t(input int target, output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (t != target && n < 40000) begin
            @(negedge clk);
            n++;
        end
        ok = (t == target);
        if (!ok) chk("wait_timeout", 32'(t), 32'(target));
    endtask

    initial begin
        bit ok;
        tbl[0]  = '{0,     10'd0,   10'd0,   pk(0, 0, 3'd0, 3'd0, 2'd0, 0)};
        tbl[1]  = '{1,     10'd1,   10'd0,   pk(0, 0, 3'd0, 3'd0, 2'd0, 0)};
        tbl[2]  = '{2,     10'd2,   10'd0,   pk(0, 0, 3'd0, 3'd0, 2'd0, 1)};
        tbl[3]  = '{167,   10'd167, 10'd0,   pk(0, 0, 3'd5, 3'd1, 2'd1, 0)};
        tbl[4]  = '{801,   10'h3FF, 10'h3FF, pk(0, 0, 3'd0, 3'd7, 2'd3, 0)};
        tbl[5]  = '{802,   10'h3FF, 10'h3FF, pk(0, 0, 3'd0, 3'd0, 2'd0, 0)};
        tbl[6]  = '{857,   10'h3FF, 10'h3FF, pk(0, 0, 3'd0, 3'd0, 2'd0, 0)};
        tbl[7]  = '{858,   10'h3FF, 10'h3FF, pk(1, 0, 3'd0, 3'd0, 2'd0, 0)};
        tbl[8]  = '{977,   10'h3FF, 10'h3FF, pk(1, 0, 3'd0, 3'd0, 2'd0, 0)};
        tbl[9]  = '{978,   10'h3FF, 10'h3FF, pk(0, 0, 3'd0, 3'd0, 2'd0, 0)};
        tbl[10] = '{1045,  10'd5,   10'd1,   pk(0, 0, 3'd0, 3'd0, 2'd3, 0)};
        tbl[11] = '{6340,  10'h3FF, 10'h3FF, pk(0, 0, 3'd0, 3'd0, 2'd0, 0)};
        tbl[12] = '{8321,  10'h3FF, 10'h3FF, pk(0, 0, 3'd0, 3'd0, 2'd0, 0)};
        tbl[13] = '{8322,  10'h3FF, 10'h3FF, pk(0, 1, 3'd0, 3'd0, 2'd0, 0)};
        tbl[14] = '{10401, 10'h3FF, 10'h3FF, pk(0, 1, 3'd0, 3'd0, 2'd0, 0)};
        tbl[15] = '{10402, 10'h3FF, 10'h3FF, pk(0, 0, 3'd0, 3'd0, 2'd0, 0)};
        tbl[16] = '{12481, 10'd1,   10'd0,   pk(0, 0, 3'd0, 3'd0, 2'd0, 0)};
        tbl[17] = '{12482, 10'd2,   10'd0,   pk(0, 0, 3'd0, 3'd0, 2'd0, 1)};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            wait_t(tbl[i].t, ok);
            if (ok) begin
                chk("tbl_hc", {22'd0, hc}, {22'd0, tbl[i].hc});
                chk("tbl_vc", {22'd0, vc}, {22'd0, tbl[i].vc});
                chk("tbl_pins", {21'd0, hs, vs, r, g, b, fs}, {21'd0, tbl[i].pins});
            end
        end

        wait_t(24000, ok);
        chk("fs_count", 32'(fs_q.size()), 32'd2);
        if (fs_q.size() == 2) begin
            chk("fs_first", 32'(fs_q[0]), 32'(LAT));
            chk("fs_period", 32'(fs_q[1] - fs_q[0]), 32'(FRAME));
        end

        // Mid-frame reset while the counters sit at line 3, column 400.
        wait_t(2 * FRAME + 3 * HT + 399, ok);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("pre_rst_hc", {22'd0, hc}, 32'd400);
        chk("pre_rst_vc", {22'd0, vc}, 32'd3);
        fs_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_hc", {22'd0, hc}, 32'd0);
        chk("rst_vc", {22'd0, vc}, 32'd0);
        chk("rst_pins0", {21'd0, hs, vs, r, g, b, fs}, 32'd0);
        @(negedge clk);
        chk("rst_pins1", {21'd0, hs, vs, r, g, b, fs}, 32'd0);
        @(negedge clk);
        chk("rst_pins2", {21'd0, hs, vs, r, g, b, fs}, 32'd1);

        wait_t(3000, ok);
        chk("rst_fs_count", 32'(fs_q.size()), 32'd1);
        if (fs_q.size() == 1) chk("rst_fs_first", 32'(fs_q[0]), 32'(LAT));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
